// File: rtl/hz_stopwatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hz_stopwatch                                               |
// | Description : BCD MM:SS stopwatch advanced by rising edges of a ~1 Hz    |
// |               level, with start/stop/clear control.                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hz_stopwatch #(
    parameter int MAX_MIN = 59,
    parameter int WRAP    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hz_clk,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_clear,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_min_tens,
    output logic       o_tick,
    output logic       o_running,
    output logic       o_rollover
);

    localparam logic [1:0] c_STOPPED = 2'b00;
    localparam logic [1:0] c_RUNNING = 2'b01;
    localparam logic [1:0] c_PAUSED  = 2'b10;

    localparam logic [3:0] c_MAX_MIN_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] c_MAX_MIN_ONES = 4'(MAX_MIN % 10);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_hz_prev;
    logic       r_tick;
    logic       r_rollover;
    logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic [3:0] w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;
    logic       w_rise;
    logic       w_count;
    logic       w_at_max;

    assign w_rise   = i_hz_clk & ~r_hz_prev;
    // Counting uses the pre-edge state, so a stop arriving with a rise still counts.
    assign w_count  = w_rise & (r_state == c_RUNNING) & ~i_clear;
    assign w_at_max = (r_sec_ones == 4'd9) && (r_sec_tens == 4'd5) &&
                      (r_min_ones == c_MAX_MIN_ONES) && (r_min_tens == c_MAX_MIN_TENS);

    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = c_STOPPED;
        end else if (i_start && i_stop) begin
            w_state_next = r_state;
        end else if (i_start && (r_state != c_RUNNING)) begin
            w_state_next = c_RUNNING;
        end else if (i_stop && (r_state == c_RUNNING)) begin
            w_state_next = c_PAUSED;
        end
    end

    always_comb begin
        w_sec_ones = r_sec_ones;
        w_sec_tens = r_sec_tens;
        w_min_ones = r_min_ones;
        w_min_tens = r_min_tens;
        if (w_at_max) begin
            if (WRAP != 0) begin
                w_sec_ones = 4'd0;
                w_sec_tens = 4'd0;
                w_min_ones = 4'd0;
                w_min_tens = 4'd0;
            end
        end else if (r_sec_ones != 4'd9) begin
            w_sec_ones = r_sec_ones + 4'd1;
        end else begin
            w_sec_ones = 4'd0;
            if (r_sec_tens != 4'd5) begin
                w_sec_tens = r_sec_tens + 4'd1;
            end else begin
                w_sec_tens = 4'd0;
                if (r_min_ones != 4'd9) begin
                    w_min_ones = r_min_ones + 4'd1;
                end else begin
                    w_min_ones = 4'd0;
                    w_min_tens = (r_min_tens == 4'd9) ? 4'd0 : r_min_tens + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_hz_prev <= i_hz_clk;
        if (i_rst) begin
            r_state    <= c_STOPPED;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_tick     <= w_rise;
            r_rollover <= w_count & w_at_max;
            if (i_clear) begin
                r_sec_ones <= 4'd0;
                r_sec_tens <= 4'd0;
                r_min_ones <= 4'd0;
                r_min_tens <= 4'd0;
            end else if (w_count) begin
                r_sec_ones <= w_sec_ones;
                r_sec_tens <= w_sec_tens;
                r_min_ones <= w_min_ones;
                r_min_tens <= w_min_tens;
            end
        end
    end

    assign o_sec_ones = r_sec_ones;
    assign o_sec_tens = r_sec_tens;
    assign o_min_ones = r_min_ones;
    assign o_min_tens = r_min_tens;
    assign o_tick     = r_tick;
    assign o_running  = (r_state == c_RUNNING);
    assign o_rollover = r_rollover;

endmodule
`default_nettype wire
